// File: rtl/mult_div_sequencer_pkg.sv
// mult_div_sequencer_pkg
// Shared definitions between the MULT/DIV engine and the main control FSM.
//   - OP_MULT / OP_DIV : encoding of the 'op' input of mult_div_sequencer
//   - mc_wait_e        : main-control states that wait for the engine's done
package mult_div_sequencer_pkg;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Main-control handshake states that sit waiting on 'done'.
  typedef enum logic {
    MULT_WAIT = 1'b0,
    DIV_WAIT  = 1'b1
  } mc_wait_e;

endpackage

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer
// Multicycle signed MULT/DIV engine producing Hi/Lo for the multicycle CPU.
// One result bit per cycle: shift-add multiply or restoring divide on the
// operand magnitudes, followed by a single sign-fix cycle.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset
//   start    in   one-cycle request, only honoured in IDLE
//   op       in   0 = MULT, 1 = DIV (sampled with start)
//   a, b     in   WIDTH-bit two's complement operands (sampled with start)
//   busy     out  high from the cycle after an accepted start through done
//   done     out  one-cycle completion pulse
//   div_zero out  high with done for DIV by zero
//   hi, lo   out  MULT: product high/low; DIV: remainder/quotient
module mult_div_sequencer
  import mult_div_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4,
    S_DZ   = 3'd5
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic             r_op;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [WIDTH-1:0] r_a_mag;
  logic [WIDTH-1:0] r_b_mag;
  // r_acc: product high half (MULT) / partial remainder (DIV)
  // r_shf: multiplier shifting out + product low half (MULT) /
  //        dividend shifting out + quotient shifting in (DIV)
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_shf;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Magnitudes as unsigned values; the most negative input maps to 2^(WIDTH-1),
  // which still fits the unsigned WIDTH-bit register.
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_b_zero;
  logic               w_last;
  logic [WIDTH-1:0]   w_rem_sh;
  logic [WIDTH:0]     w_add_opd;
  logic [WIDTH:0]     w_addsub;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quot_s;
  logic [WIDTH-1:0]   w_rem_s;

  assign w_a_mag  = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign w_b_mag  = b[WIDTH-1] ? (~b + 1'b1) : b;
  assign w_b_zero = (b == '0);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // Single WIDTH+1-bit add/sub shared by both algorithms. The extra bit is the
  // multiply carry-out, or the borrow (negative trial result) for division.
  assign w_rem_sh  = {r_acc[WIDTH-2:0], r_shf[WIDTH-1]};
  assign w_add_opd = r_shf[0] ? {1'b0, r_a_mag} : '0;
  assign w_addsub  = (r_op == OP_DIV) ? ({1'b0, w_rem_sh} - {1'b0, r_b_mag})
                                      : ({1'b0, r_acc} + w_add_opd);

  // Sign application for the fix-up cycle.
  assign w_prod   = {r_acc, r_shf};
  assign w_prod_s = (r_sign_a ^ r_sign_b) ? (~w_prod + 1'b1) : w_prod;
  assign w_quot_s = (r_sign_a ^ r_sign_b) ? (~r_shf + 1'b1) : r_shf;
  assign w_rem_s  = r_sign_a ? (~r_acc + 1'b1) : r_acc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (op == OP_DIV && w_b_zero) begin
            w_state_next = S_DZ;
          end else begin
            w_state_next = S_PREP;
          end
        end
      end
      S_PREP:  w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      S_DZ:    w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_a_mag  <= '0;
      r_b_mag  <= '0;
      r_acc    <= '0;
      r_shf    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_state_next == S_PREP) begin
            r_op     <= op;
            r_sign_a <= a[WIDTH-1];
            r_sign_b <= b[WIDTH-1];
            r_a_mag  <= w_a_mag;
            r_b_mag  <= w_b_mag;
          end
        end
        S_PREP: begin
          r_acc <= '0;
          r_shf <= (r_op == OP_DIV) ? r_a_mag : r_b_mag;
          r_cnt <= '0;
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op == OP_DIV) begin
            // Borrow set means the trial subtraction went negative: restore.
            r_acc <= w_addsub[WIDTH] ? w_rem_sh : w_addsub[WIDTH-1:0];
            r_shf <= {r_shf[WIDTH-2:0], ~w_addsub[WIDTH]};
          end else begin
            {r_acc, r_shf} <= {w_addsub, r_shf[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (r_op == OP_DIV) begin
            r_hi <= w_rem_s;
            r_lo <= w_quot_s;
          end else begin
            {r_hi, r_lo} <= w_prod_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE) || (r_state == S_DZ);
  assign div_zero = (r_state == S_DZ);
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_mult_div_sequencer.sv
module tb_mult_div_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  mult_div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (div_zero && !done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL div_zero_without_done: got 1 expected 0 at cycle %0d", cyc);
    end
    if (done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_done++;
        $display("txn cycle=%0d hi=0x%08h lo=0x%08h div_zero=%0b", cyc, hi, lo, div_zero);
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("div_zero", div_zero, e.dz);
        check("latency", cyc, e.cyc);
      end
    end
  end

  // Issue one operation, wait for its done, and check busy behaviour.
  // inject_at >= 0 pulses a second start (DIV 9/0) at that wait iteration.
  task automatic run_op(input logic o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int inject_at);
    exp_t e;
    int   k;
    int   busy_cnt;
    bit   got;
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    e.hi = ehi; e.lo = elo; e.dz = edz; e.cyc = edz ? k : k + 34;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        got = 1'b1;
      end else begin
        if (i == inject_at) begin
          start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd0;
        end else if (i == inject_at + 1) begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
    end
    check("busy_cycles", busy_cnt, edz ? 1 : 35);
    @(negedge clk);
    check("busy_after_done", busy, 1'b0);
    check("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_div_zero", div_zero, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);

    // 7 * -3 = -21
    run_op(1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, -1);
    // (-2^31) * (-2^31) = 2^62
    run_op(1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, -1);
    // -7 / 2 = -3 rem -1
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, -1);
    // -2^31 / -1 wraps to -2^31 rem 0
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, -1);
    // 100 / -7 = -14 rem 2
    run_op(1'b1, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 1'b0, -1);
    // zero operand still takes full latency
    run_op(1'b0, 32'd0, 32'h1234, 32'd0, 32'd0, 1'b0, -1);
    // 6 * 0x2AAAAAAB = 0x1_00000002 -> hi=1, lo=2
    run_op(1'b0, 32'd6, 32'h2AAAAAAB, 32'd1, 32'd2, 1'b0, -1);
    // divide by zero: hi/lo retained
    run_op(1'b1, 32'd5, 32'd0, 32'd1, 32'd2, 1'b1, -1);

    // start during RUN is ignored
    d0 = n_done;
    run_op(1'b0, 32'd100, 32'd200, 32'd0, 32'd20000, 1'b0, 5);
    repeat (40) @(negedge clk);
    #1;
    check("ignored_start_done_count", n_done - d0, 1);

    // reset mid-operation
    @(negedge clk);
    op = 1'b0; a = 32'd55; b = 32'd66; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    d0 = n_done;
    repeat (40) @(negedge clk);
    #1;
    check("midrst_no_done", n_done - d0, 0);
    run_op(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, -1);

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
